// File: rtl/bus_reg_bank_pkg.sv
// Shared constants for the bus register bank: slot map, slot count, default width.
package bus_reg_bank_pkg;

  localparam int DEF_WORD_SIZE = 32;
  localparam int NUM_SLOTS = 32;

  localparam int SLOT_R0 = 0;
  localparam int SLOT_R15 = 15;
  localparam int SLOT_HI = 16;
  localparam int SLOT_LO = 17;
  localparam int SLOT_ZHI = 18;
  localparam int SLOT_ZLO = 19;
  localparam int SLOT_PC = 20;
  localparam int SLOT_MDR = 21;
  localparam int SLOT_INPORT = 22;
  localparam int SLOT_CSIGN = 23;
  localparam int SLOT_RSVD_FIRST = 24;

  // True when two or more bits are set.
  function automatic logic multi_hot(
    input logic [SLOT_RSVD_FIRST-1:0] v
  );
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/bus_reg_bank_if.sv
// Bus-side signal bundle for bus_reg_bank.
interface bus_reg_bank_if
  import bus_reg_bank_pkg::*;
#(
  parameter int W = DEF_WORD_SIZE
) ();

  logic [W-1:0]           bus_in;
  logic [NUM_SLOTS-1:0]   wr_en;
  logic                   mdr_read;
  logic [W-1:0]           mem_data;
  logic                   z_in;
  logic [2*W-1:0]         alu_result;
  logic                   pc_inc;
  logic                   in_strobe;
  logic [W-1:0]           in_port_data;
  logic                   ba_out;
  logic                   err_clr;
  logic [NUM_SLOTS*W-1:0] reg_out;
  logic                   multi_wr_err;

  modport master (
    output bus_in, wr_en, mdr_read, mem_data,
    output z_in, alu_result, pc_inc,
    output in_strobe, in_port_data,
    output ba_out, err_clr,
    input  reg_out, multi_wr_err
  );

  modport slave (
    input  bus_in, wr_en, mdr_read, mem_data,
    input  z_in, alu_result, pc_inc,
    input  in_strobe, in_port_data,
    input  ba_out, err_clr,
    output reg_out, multi_wr_err
  );

endinterface

// File: rtl/bus_reg_bank_word.sv
// One bank word: W-bit register, async active-low clear, load enable.
module bus_reg_word #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/bus_reg_bank.sv
// 32-slot bus-visible register bank; slots 24-31 are reserved and read 0.
// BUS_REG_BANK_BYPASS_EN: bus writes show on reg_out in the same cycle.
module bus_reg_bank
  import bus_reg_bank_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int PC_STEP = 1
) (
  input logic        clock,
  input logic        clear_n,
  bus_reg_bank_if.slave bus
);

  localparam int W = WORD_SIZE;
  localparam int NW = SLOT_RSVD_FIRST;

  logic [NW-1:0] ld;
  logic [W-1:0]  d  [NW];
  logic [W-1:0]  q  [NW];
  logic [W-1:0]  rd [NW];
  logic [NW-1:0] bus_ld;
  logic          err_q;

  assign bus_ld = bus.wr_en[NW-1:0];

  always_comb begin
    for (int k = 0; k < NW; k++) begin
      ld[k] = bus_ld[k];
      d[k]  = bus.bus_in;
    end
    // Dedicated sources and their priority over the bus load.
    ld[SLOT_ZHI] = bus_ld[SLOT_ZHI] | bus.z_in;
    ld[SLOT_ZLO] = bus_ld[SLOT_ZLO] | bus.z_in;
    if (bus.z_in) begin
      d[SLOT_ZHI] = bus.alu_result[2*W-1:W];
      d[SLOT_ZLO] = bus.alu_result[W-1:0];
    end
    ld[SLOT_PC] = bus_ld[SLOT_PC] | bus.pc_inc;
    if (!bus_ld[SLOT_PC])
      d[SLOT_PC] = q[SLOT_PC] + W'(PC_STEP);
    if (bus.mdr_read)
      d[SLOT_MDR] = bus.mem_data;
    ld[SLOT_INPORT] = bus_ld[SLOT_INPORT] | bus.in_strobe;
    if (bus.in_strobe)
      d[SLOT_INPORT] = bus.in_port_data;
  end

  for (genvar k = 0; k < NW; k++) begin : g_word
    bus_reg_word #(.W(W)) u_word (
      .clk   (clock),
      .rst_n (clear_n),
      .ld    (ld[k]),
      .d     (d[k]),
      .q     (q[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NW; k++) begin
      rd[k] = q[k];
`ifdef BUS_REG_BANK_BYPASS_EN
      if (bus_ld[k]) rd[k] = bus.bus_in;
`endif
    end
    // Base-address mode hides R0 on the read path only.
    if (bus.ba_out) rd[SLOT_R0] = '0;
  end

  always_comb begin
    bus.reg_out = '0;
    for (int k = 0; k < NW; k++)
      bus.reg_out[k*W +: W] = rd[k];
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)               err_q <= 1'b0;
    else if (multi_hot(bus_ld)) err_q <= 1'b1;
    else if (bus.err_clr)       err_q <= 1'b0;
  end

  assign bus.multi_wr_err = err_q;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Directed self-checking bench for bus_reg_bank.
module tb_bus_reg_bank;

  localparam int W = 32;

  logic clock = 1'b0;
  logic clear_n;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  bus_reg_bank_if #(.W(W)) bus ();

  bus_reg_bank #(.WORD_SIZE(W), .PC_STEP(1)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  function automatic logic [W-1:0] slot(input int k);
    return bus.reg_out[k*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = '0;
    bus.z_in = 1'b0;
    bus.pc_inc = 1'b0;
    bus.mdr_read = 1'b0;
    bus.in_strobe = 1'b0;
    bus.err_clr = 1'b0;
    bus.ba_out = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_SLOT_BITS()-1:0] zero_vec;
    zero_vec = '0;
    clear_n = 1'b0;
    bus.bus_in = '0;
    bus.mem_data = '0;
    bus.alu_result = '0;
    bus.in_port_data = '0;
    idle();
    #12;
    chk("reset_all", {63'd0, bus.reg_out == zero_vec}, 64'd1);
    chk("reset_err", {63'd0, bus.multi_wr_err}, 64'd0);
    clear_n = 1'b1;

    // Preload every slot, then async clear between edges.
    bus.wr_en = 32'h00FF_FFFF;
    bus.bus_in = 32'h0000_0011;
    tick();
    idle();
    chk("preload_s23", slot(23), 32'h11);
    chk("preload_err", {63'd0, bus.multi_wr_err}, 64'd1);
    #2 clear_n = 1'b0;
    #1;
    chk("clr_all", {63'd0, bus.reg_out == zero_vec}, 64'd1);
    chk("clr_err", {63'd0, bus.multi_wr_err}, 64'd0);
    clear_n = 1'b1;

    // Bus load and reserved slot.
    bus.bus_in = 32'hDEAD_BEEF;
    bus.wr_en = 32'h1 << 5;
    tick();
    idle();
    chk("load_s5", slot(5), 32'hDEAD_BEEF);
    chk("load_s4", slot(4), 32'h0);
    bus.bus_in = 32'h1234;
    bus.wr_en = 32'h1 << 27;
    tick();
    idle();
    chk("rsvd_s27", slot(27), 32'h0);
    chk("keep_s5", slot(5), 32'hDEAD_BEEF);

    // Z priority over bus.
    bus.z_in = 1'b1;
    bus.alu_result = 64'h1_0000_0002;
    bus.wr_en = 32'h1 << 19;
    bus.bus_in = 32'd7;
    tick();
    idle();
    chk("zhi", slot(18), 32'h1);
    chk("zlo", slot(19), 32'h2);

    // PC wrap and bus-over-increment priority.
    bus.wr_en = 32'h1 << 20;
    bus.bus_in = 32'hFFFF_FFFF;
    tick();
    idle();
    chk("pc_load", slot(20), 32'hFFFF_FFFF);
    bus.pc_inc = 1'b1;
    tick();
    idle();
    chk("pc_wrap", slot(20), 32'h0);
    bus.wr_en = 32'h1 << 20;
    bus.bus_in = 32'd40;
    bus.pc_inc = 1'b1;
    tick();
    idle();
    chk("pc_prio", slot(20), 32'd40);
    bus.pc_inc = 1'b1;
    tick();
    idle();
    chk("pc_inc", slot(20), 32'd41);

    // MDR source select.
    bus.wr_en = 32'h1 << 21;
    bus.mdr_read = 1'b1;
    bus.mem_data = 32'hA5A5;
    tick();
    idle();
    chk("mdr_mem", slot(21), 32'hA5A5);
    bus.wr_en = 32'h1 << 21;
    bus.bus_in = 32'd3;
    tick();
    idle();
    chk("mdr_bus", slot(21), 32'd3);
    bus.mdr_read = 1'b1;
    bus.mem_data = 32'hFFFF;
    tick();
    idle();
    chk("mdr_hold", slot(21), 32'd3);

    // INPORT strobe priority.
    bus.in_strobe = 1'b1;
    bus.in_port_data = 32'd77;
    bus.wr_en = 32'h1 << 22;
    bus.bus_in = 32'd5;
    tick();
    idle();
    chk("inport", slot(22), 32'd77);

    // Base-address masking.
    bus.wr_en = 32'h1;
    bus.bus_in = 32'd9;
    tick();
    idle();
    bus.ba_out = 1'b1;
    #1;
    chk("ba_on", slot(0), 32'h0);
    bus.ba_out = 1'b0;
    #1;
    chk("ba_off", slot(0), 32'd9);

    // Multi-write error, clear, and set-beats-clear.
    bus.wr_en = 32'h3;
    bus.bus_in = 32'hAB;
    tick();
    idle();
    chk("multi_r0", slot(0), 32'hAB);
    chk("multi_r1", slot(1), 32'hAB);
    chk("multi_err", {63'd0, bus.multi_wr_err}, 64'd1);
    bus.err_clr = 1'b1;
    tick();
    idle();
    chk("err_clr", {63'd0, bus.multi_wr_err}, 64'd0);
    bus.err_clr = 1'b1;
    bus.wr_en = 32'h6;
    bus.bus_in = 32'h66;
    tick();
    idle();
    chk("err_beats_clr", {63'd0, bus.multi_wr_err}, 64'd1);
    chk("multi_r2", slot(2), 32'h66);

    // Reset asserted across a write edge aborts it.
    @(negedge clock);
    bus.wr_en = 32'h1 << 2;
    bus.bus_in = 32'h99;
    clear_n = 1'b0;
    tick();
    idle();
    clear_n = 1'b1;
    chk("abort_s2", slot(2), 32'h0);

    // Same-cycle view of a bus write.
    bus.wr_en = 32'h1 << 3;
    bus.bus_in = 32'd55;
    #1;
`ifdef BUS_REG_BANK_BYPASS_EN
    chk("bypass_s3", slot(3), 32'd55);
`else
    chk("nobypass_s3", slot(3), 32'd0);
`endif
    tick();
    idle();
    chk("stored_s3", slot(3), 32'd55);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  function automatic int NUM_SLOT_BITS();
    return 32 * W;
  endfunction

endmodule
